// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyphs, anode
// encodings and FSM state codes.
package seg_scan_driver_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] ANODE_OFF = 4'hF;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  function automatic logic [3:0] anode_sel(input logic [1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the digit source and the scanner: digit values,
// decimal points and enables in; shared segments, anodes and frame marker out.
interface seg_scan_driver_if;

  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  anode_n;
  logic [7:0]  seg_n;
  logic        frame_start;

  modport master (
    output digits_in, dp_in, digit_en,
    input  anode_n, seg_n, frame_start
  );

  modport slave (
    input  digits_in, dp_in, digit_en,
    output anode_n, seg_n, frame_start
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder; active-low a..g, no decimal point.
module seg_hex_decode
  import seg_scan_driver_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph_n
);

    logic [7:0] glyph_full;

    always_comb begin
        glyph_full = SEG_BLANK;
        case (value)
            4'h0: glyph_full = SEG_0;
            4'h1: glyph_full = SEG_1;
            4'h2: glyph_full = SEG_2;
            4'h3: glyph_full = SEG_3;
            4'h4: glyph_full = SEG_4;
            4'h5: glyph_full = SEG_5;
            4'h6: glyph_full = SEG_6;
            4'h7: glyph_full = SEG_7;
            4'h8: glyph_full = SEG_8;
            4'h9: glyph_full = SEG_9;
            4'hA: glyph_full = SEG_A;
            4'hB: glyph_full = SEG_B;
            4'hC: glyph_full = SEG_C;
            4'hD: glyph_full = SEG_D;
            4'hE: glyph_full = SEG_E;
            default: glyph_full = SEG_F;
        endcase
    end

    assign glyph_n = glyph_full[6:0];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-frame input snapshot,
// blanking gap at the start of every slot and optional leading-zero blanking.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input logic              sysclock,
    input logic              reset_n,
    seg_scan_driver_if.slave bus
);

    localparam int                 PRESC_W    = $clog2(SCAN_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_LAST = PRESC_W'(BLANK_CYCLES - 1);

    logic [PRESC_W-1:0] presc;
    logic [1:0]         slot;
    logic [0:0]         state;
    logic [15:0]        snap_digits;
    logic [3:0]         snap_dp;
    logic [3:0]         snap_en;
    logic [3:0]         anode_q;
    logic [7:0]         seg_q;
    logic               frame_start_q;

    logic               frame_first;
    logic [3:0]         cur_digit;
    logic [6:0]         cur_glyph;
    logic               z3, z2, z1;
    logic [3:0]         lz_mask;
    logic               cur_visible;

    assign frame_first = (presc == '0) && (slot == 2'd0);
    assign cur_digit   = snap_digits[{slot, 2'b00} +: 4];

    // A digit is blanked only while it and everything above it are zero.
    assign z3      = (snap_digits[15:12] == 4'd0);
    assign z2      = (snap_digits[11:8]  == 4'd0);
    assign z1      = (snap_digits[7:4]   == 4'd0);
    assign lz_mask = LZ_SUPPRESS ? {z3, z3 & z2, z3 & z2 & z1, 1'b0} : 4'b0000;

    assign cur_visible = snap_en[slot] & ~lz_mask[slot];

    seg_hex_decode u_decode (
        .value   (cur_digit),
        .glyph_n (cur_glyph)
    );

    always_ff @(posedge sysclock or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            slot  <= 2'd0;
            state <= ST_BLANK;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            slot  <= slot + 2'd1;
            state <= ST_BLANK;
        end else begin
            presc <= presc + 1'b1;
            if (presc == BLANK_LAST) begin
                state <= ST_SHOW;
            end
        end
    end

    always_ff @(posedge sysclock or negedge reset_n) begin
        if (!reset_n) begin
            snap_digits <= 16'h0000;
            snap_dp     <= 4'h0;
            snap_en     <= 4'h0;
        end else if (frame_first) begin
            snap_digits <= bus.digits_in;
            snap_dp     <= bus.dp_in;
            snap_en     <= bus.digit_en;
        end
    end

    // Outputs follow the counters by one cycle, so anodes and segments move together.
    always_ff @(posedge sysclock or negedge reset_n) begin
        if (!reset_n) begin
            anode_q       <= ANODE_OFF;
            seg_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_first;
            if (state == ST_SHOW) begin
                anode_q <= cur_visible ? anode_sel(slot) : ANODE_OFF;
                seg_q   <= {~snap_dp[slot], cur_glyph};
            end else begin
                anode_q <= ANODE_OFF;
                seg_q   <= SEG_BLANK;
            end
        end
    end

    assign bus.anode_n     = anode_q;
    assign bus.seg_n       = seg_q;
    assign bus.frame_start = frame_start_q;

endmodule
